left_shift_rotator_seq: RTL and testbench
=========================================

Name: left_shift_rotator_seq

Overview:
- Multi-cycle left shifter/rotator for the 16-bit datapath. It is the left-direction counterpart to the combinational right shift/rotate unit.
- It accepts one operation through a start/busy/done handshake, then shifts a working register left by up to STEP bits per clock.
- It is used where left shifts/rotates are moved off the single-cycle critical path, as an execute-stage coprocessor that stalls the pipeline while busy.

Parameters:
- WIDTH, 16, data width; must be a power of 2, at least 4.
- STEP, 1, bits shifted per cycle; legal values are 1, 2, 4 or 8, and STEP must not exceed WIDTH/2.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only on an edge where busy==0.
- In  input  WIDTH  operand, sampled on the accept edge.
- shift  input  1  1 = logical shift left (zero fill); 0 = rotate left. Sampled on accept.
- ShAmt  input  SHW  shift/rotate amount, 0 to WIDTH-1. Sampled on accept.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; out is valid in this cycle.
- out  output  WIDTH  working/result register.

Behaviour:
- Reset (async assert, sync-release assumed upstream):
  - state=IDLE; out=0, busy=0, done=0; rem=0, mode=0.
  - Takes effect immediately, including mid-operation; the aborted operation produces no done.
- States: IDLE, RUN, DONE.
- IDLE / DONE:
  - busy=0. done=1 only in DONE.
  - On an edge with start=1: out<=In, mode<=shift, rem<=ShAmt.
  - Next state is RUN if ShAmt!=0, else DONE.
  - Otherwise DONE goes to IDLE; IDLE stays IDLE.
- RUN:
  - busy=1, done=0. Each edge shifts by k=min(STEP, rem), rem<=rem-k.
  - Next state is DONE when rem==k, else stays RUN.
  - Shift: out<=out<<k with k zeros in the LSBs.
  - Rotate: the k bits leaving the MSB end re-enter at the LSB end.
- start during RUN is ignored: no queueing, no effect on rem, mode or out.
- Latency:
  - Let E0 be the accept edge. done is high exactly in the cycle after edge E_N, where N=ceil(ShAmt/STEP).
  - busy is high from after E0 through E_N (N cycles). ShAmt=0 gives N=0: done in the cycle after E0, busy never rises.
- Back-to-back: start accepted in the DONE cycle begins the next operation; done drops on that edge.
- out:
  - Holds the intermediate value during RUN; consumers sample it only when done=1.
  - Holds the result in IDLE until the next accept.
- Result: equals the single-step left shift/rotate of In by ShAmt, independent of STEP.
- Inputs other than start are don't-care except on the accept edge.
- X on start after reset is not permitted.

Test Plan:
- STEP=1: rotate, In=16'h8001, ShAmt=1 → out=16'h0003, done in the cycle after E1, busy high 1 cycle.
- STEP=1: shift, In=16'hFFFF, ShAmt=15 → out=16'h8000, busy high 15 cycles, done after E15. Then rotate In=16'hABCD, ShAmt=8 → 16'hCDAB.
- ShAmt=0, In=16'h1234, shift=0 and shift=1 → out=16'h1234, done in the cycle after E0, busy stays 0.
- STEP=4: rotate, In=16'h1234, ShAmt=5 → out=16'h4682, done after E2. Shift, In=16'h1234, ShAmt=5 → 16'h4680.
- Handshake:
  - Pulse start with In=16'h0F0F while busy → ignored, first result unchanged.
  - Start in the DONE cycle → second operation accepted, done pulses exactly twice, results correct.
- Reset mid-RUN (ShAmt=12, STEP=1, rst_n low at cycle 5) → out=0, busy=0, done=0 immediately, no done pulse. After release, a new start completes normally.
- Random regression: 2000 random (In, shift, ShAmt) for each STEP, compared against a behavioural left shift/rotate model; latency checked against ceil(ShAmt/STEP).

Source files
------------

// File: rtl/left_shift_rotator_seq.sv
// Multi-cycle left shifter/rotator with a start/busy/done handshake.
// Moves up to STEP bits per clock so wide shifts stay off the critical path.
module left_shift_rotator_seq #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] In,
    input  logic             shift,
    input  logic [SHW-1:0]   ShAmt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [SHW-1:0] STEP_K  = STEP[SHW-1:0];
    localparam logic [SHW:0]   WIDTH_N = WIDTH[SHW:0];

    state_t           state;
    logic [SHW-1:0]   rem;
    logic             mode;
    logic [SHW-1:0]   k;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] rol;
    logic [WIDTH-1:0] nxt;

    // k is never zero in RUN, so WIDTH-k stays below WIDTH
    always_comb begin
        k   = (rem < STEP_K) ? rem : STEP_K;
        shl = out << k;
        rol = shl | (out >> (WIDTH_N - {1'b0, k}));
        nxt = mode ? shl : rol;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            rem   <= '0;
            mode  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        out  <= In;
                        mode <= shift;
                        rem  <= ShAmt;
                        if (ShAmt != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    out <= nxt;
                    rem <= rem - k;
                    if (rem == k) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        busy <= 1'b1;
                        done <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_left_shift_rotator_seq.sv
// Directed and random checks of left_shift_rotator_seq for STEP = 1, 2, 4, 8.
// Each STEP variant has its own start/busy/done/out; data inputs are shared.
module tb_left_shift_rotator_seq;

    logic             clk;
    logic             rst_n;
    logic [3:0]       start_v;
    logic [15:0]      din;
    logic             sh;
    logic [3:0]       amt;
    logic [3:0]       busy_v;
    logic [3:0]       done_v;
    logic [3:0][15:0] out_v;

    int n_cmp;
    int n_err;
    int dpulses;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        left_shift_rotator_seq #(
            .WIDTH(16),
            .STEP (1 << g)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .start(start_v[g]),
            .In   (din),
            .shift(sh),
            .ShAmt(amt),
            .busy (busy_v[g]),
            .done (done_v[g]),
            .out  (out_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (done_v[0]) dpulses++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] d,
                                          input logic s,
                                          input logic [3:0] a);
        logic [15:0] l;
        l = d << a;
        if (s) return l;
        return l | (d >> (16 - int'(a)));
    endfunction

    task automatic launch(input int idx, input logic [15:0] d,
                          input logic s, input logic [3:0] a);
        @(negedge clk);
        din = d;
        sh = s;
        amt = a;
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
    endtask

    task automatic finish_op(input int idx, input logic [15:0] exp,
                             input int n, input string tag);
        int lat;
        int bcnt;
        lat = 0;
        bcnt = 0;
        while (!done_v[idx] && lat < 40) begin
            if (busy_v[idx]) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".out"}, 32'(out_v[idx]), 32'(exp));
        check({tag, ".lat"}, 32'(lat), 32'(n));
        check({tag, ".busy"}, 32'(bcnt), 32'(n));
    endtask

    task automatic run_op(input int idx, input logic [15:0] d,
                          input logic s, input logic [3:0] a,
                          input logic [15:0] exp, input int n,
                          input string tag);
        launch(idx, d, s, a);
        finish_op(idx, exp, n, tag);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        dpulses = 0;
        start_v = '0;
        din = '0;
        sh = 1'b0;
        amt = '0;
        rst_n = 1'b0;
        #23;
        for (int i = 0; i < 4; i++) begin
            check("rst.out", 32'(out_v[i]), 32'h0);
            check("rst.busy", 32'(busy_v[i]), 32'h0);
            check("rst.done", 32'(done_v[i]), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_op(0, 16'h8001, 1'b0, 4'd1, 16'h0003, 1, "s1_rol1");
        repeat (3) @(posedge clk);

        dpulses = 0;
        run_op(0, 16'hFFFF, 1'b1, 4'd15, 16'h8000, 15, "s1_shl15");
        run_op(0, 16'hABCD, 1'b0, 4'd8, 16'hCDAB, 8, "s1_rol8");
        repeat (3) @(posedge clk);
        check("b2b.pulses", 32'(dpulses), 32'd2);

        run_op(0, 16'h1234, 1'b0, 4'd0, 16'h1234, 0, "s1_rol0");
        repeat (2) @(posedge clk);
        run_op(0, 16'h1234, 1'b1, 4'd0, 16'h1234, 0, "s1_shl0");
        repeat (2) @(posedge clk);

        run_op(2, 16'h1234, 1'b0, 4'd5, 16'h4682, 2, "s4_rol5");
        run_op(2, 16'h1234, 1'b1, 4'd5, 16'h4680, 2, "s4_shl5");
        repeat (2) @(posedge clk);

        dpulses = 0;
        fork
            begin
                launch(0, 16'h1234, 1'b0, 4'd4);
                finish_op(0, 16'h2341, 4, "ign");
            end
            begin
                @(posedge clk);
                @(negedge clk);
                @(negedge clk);
                din = 16'h0F0F;
                sh = 1'b1;
                amt = 4'd3;
                start_v[0] = 1'b1;
                @(posedge clk);
                #1;
                start_v[0] = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        check("ign.pulses", 32'(dpulses), 32'd1);

        dpulses = 0;
        launch(0, 16'hFFFF, 1'b1, 4'd12);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.out", 32'(out_v[0]), 32'h0);
        check("abort.busy", 32'(busy_v[0]), 32'h0);
        check("abort.done", 32'(done_v[0]), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        check("abort.pulses", 32'(dpulses), 32'd0);
        run_op(0, 16'h00F1, 1'b0, 4'd4, 16'h0F10, 4, "post_rst");

        for (int i = 0; i < 4; i++) begin
            int stp;
            stp = 1 << i;
            for (int j = 0; j < 2000; j++) begin
                logic [15:0] d;
                logic s;
                logic [3:0] a;
                d = 16'($urandom);
                s = 1'($urandom_range(0, 1));
                a = 4'($urandom_range(0, 15));
                run_op(i, d, s, a, model(d, s, a),
                       (int'(a) + stp - 1) / stp, $sformatf("rnd%0d", stp));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
